avalon_mm_block_reader: RTL and testbench

//  Avalon-MM read master; the initiator counterpart to the slave register files.
//  On START, fetches WORD_COUNT consecutive words from BASE_ADDR.

---
 rtl/avalon_mm_block_reader.sv | 144 ++++++++++++++
 tb/tb_avalon_mm_block_reader.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_block_reader.sv
// Avalon-MM block read master: fetches a run of consecutive words and
// streams them out in order through a credit-limited FWFT FIFO.
module avalon_mm_block_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [ADDR_W-1:0]   BASE_ADDR,
    input  logic [LEN_W-1:0]    WORD_COUNT,
    output logic                BUSY,
    output logic                DONE,
    output logic                AVL_READ,
    output logic [ADDR_W-1:0]   AVL_ADDR,
    output logic [DATA_W/8-1:0] AVL_BYTE_EN,
    input  logic                AVL_WAITREQUEST,
    input  logic [DATA_W-1:0]   AVL_READDATA,
    input  logic                AVL_READDATAVALID,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  deliv_q;
    logic [CNT_W-1:0]  outst_q;
    logic [CNT_W-1:0]  fcnt_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [CNT_W:0] used;
    logic credit_ok;
    logic capture;
    logic accept;
    logic push;
    logic pop;

    // Outstanding reads reserve FIFO slots, so a push never hits a full FIFO.
    assign used      = {1'b0, outst_q} + {1'b0, fcnt_q};
    assign credit_ok = used < DEPTH_V;

    assign capture  = (state == S_IDLE) && START
                   && (WORD_COUNT != '0);
    assign AVL_READ = (state == S_ISSUE)
                   && (issued_q != len_q) && credit_ok;
    assign accept   = AVL_READ && !AVL_WAITREQUEST;
    // Stale data with nothing in flight is dropped.
    assign push     = AVL_READDATAVALID && (outst_q != '0);
    assign pop      = OUT_VALID && OUT_READY;

    assign AVL_ADDR    = addr_q;
    assign AVL_BYTE_EN = '1;
    assign OUT_VALID   = (fcnt_q != '0);
    assign OUT_DATA    = mem[rptr_q];
    assign BUSY        = (state != S_IDLE);
    assign DONE        = (state == S_FIN);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    if (WORD_COUNT != '0) state_nx = S_ISSUE;
                    else                  state_nx = S_FIN;
                end
            end
            S_ISSUE: begin
                if (issued_q == len_q) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (deliv_q == len_q) state_nx = S_FIN;
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            deliv_q  <= '0;
            outst_q  <= '0;
            fcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                addr_q   <= BASE_ADDR;
                len_q    <= WORD_COUNT;
                issued_q <= '0;
            end else if (accept) begin
                addr_q   <= addr_q + STRIDE;
                issued_q <= issued_q + 1'b1;
            end
            if (pop)     deliv_q <= deliv_q + 1'b1;
            if (capture) deliv_q <= '0;
            unique case ({accept, push})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) mem[wptr_q] <= AVL_READDATA;
    end

endmodule

// File: tb/tb_avalon_mm_block_reader.sv
// Directed bench for avalon_mm_block_reader with a latency-modelling
// Avalon slave and a stream sink driven on the falling edge.
module tb_avalon_mm_block_reader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] BASE_ADDR;
    logic [15:0] WORD_COUNT;
    logic        BUSY;
    logic        DONE;
    logic        AVL_READ;
    logic [31:0] AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic        AVL_WAITREQUEST;
    logic [31:0] AVL_READDATA;
    logic        AVL_READDATAVALID;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;

    avalon_mm_block_reader dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .START            (START),
        .BASE_ADDR        (BASE_ADDR),
        .WORD_COUNT       (WORD_COUNT),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .AVL_READ         (AVL_READ),
        .AVL_ADDR         (AVL_ADDR),
        .AVL_BYTE_EN      (AVL_BYTE_EN),
        .AVL_WAITREQUEST  (AVL_WAITREQUEST),
        .AVL_READDATA     (AVL_READDATA),
        .AVL_READDATAVALID(AVL_READDATAVALID),
        .OUT_DATA         (OUT_DATA),
        .OUT_VALID        (OUT_VALID),
        .OUT_READY        (OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [31:0] acc[$];
    logic [31:0] outq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, rd_cycles, hold_viol, waited, max_out, ov_seen;
    int wait_mode = 0;
    int wait_left = 0;
    logic [31:0] wait_addr = 32'h0;
    int lat_fix = 2;
    bit lat_rand = 0;
    bit rdy_rand = 0;
    bit rdy_force = 1;
    bit prev_hold = 0;
    logic [31:0] hold_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'hC3A5_0000) + 32'd7;
    endfunction

    // Slave, sink and monitor, all acting on the falling edge.
    initial begin
        int lat;
        forever begin
            @(negedge CLK);
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                AVL_READDATAVALID = 1'b1;
                AVL_READDATA = memf(pend[0].a);
                void'(pend.pop_front());
            end else begin
                AVL_READDATAVALID = 1'b0;
                AVL_READDATA = 32'h0;
            end
            if (prev_hold && !(AVL_READ && AVL_ADDR == hold_addr))
                hold_viol++;
            if (wait_mode == 0) begin
                AVL_WAITREQUEST = 1'b0;
            end else if (wait_mode == 1) begin
                AVL_WAITREQUEST = 1'($urandom_range(0, 1));
            end else if (AVL_READ && AVL_ADDR == wait_addr
                         && wait_left > 0) begin
                AVL_WAITREQUEST = 1'b1;
                wait_left--;
                waited++;
            end else begin
                AVL_WAITREQUEST = 1'b0;
            end
            prev_hold = AVL_READ && AVL_WAITREQUEST;
            hold_addr = AVL_ADDR;
            OUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
            if (AVL_READ) rd_cycles++;
            if (AVL_READ && !AVL_WAITREQUEST) begin
                lat = lat_rand ? int'($urandom_range(1, 5)) : lat_fix;
                pend.push_back('{AVL_ADDR, cyc + lat});
                acc.push_back(AVL_ADDR);
            end
            if (pend.size() > max_out) max_out = pend.size();
            if (OUT_VALID && OUT_READY) outq.push_back(OUT_DATA);
            if (DONE) done_cnt++;
            if (OUT_VALID) ov_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        acc.delete();
        outq.delete();
        done_cnt = 0;
        rd_cycles = 0;
        hold_viol = 0;
        waited = 0;
        max_out = 0;
        ov_seen = 0;
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [15:0] n);
        START = 1'b1;
        BASE_ADDR = b;
        WORD_COUNT = n;
        step(1);
        START = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit tmo);
        int k;
        k = 0;
        while (done_cnt == 0 && k < bound) begin
            step(1);
            k++;
        end
        tmo = (done_cnt == 0);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(3);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got %b/%b want 0/0", BUSY, DONE);
        end
        checks++;
        if (AVL_READ !== 1'b0 || AVL_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: read=%b addr=%h want 0/0",
                     AVL_READ, AVL_ADDR);
        end
        checks++;
        if (OUT_VALID !== 1'b0 || AVL_BYTE_EN !== 4'hF) begin
            errors++;
            $display("FAIL reset_out: valid=%b be=%h want 0/f",
                     OUT_VALID, AVL_BYTE_EN);
        end
        RESET = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        bit tmo;
        int bad;
        clear_logs();
        wait_mode = 0;
        lat_fix = 2;
        rdy_force = 1;
        start_xfer(32'h100, 16'd4);
        checks++;
        if (BUSY !== 1'b1 || AVL_READ !== 1'b1 || AVL_ADDR !== 32'h100) begin
            errors++;
            $display("FAIL basic_first: busy=%b read=%b addr=%h want 1/1/100",
                     BUSY, AVL_READ, AVL_ADDR);
        end
        wait_done(200, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL basic_done_timeout: no DONE within 200 cycles");
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_at_done: got %b want 1", BUSY);
        end
        step(3);
        checks++;
        if (BUSY !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_end: busy=%b dones=%0d want 0/1",
                     BUSY, done_cnt);
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= acc.size() || acc[i] !== 32'h100 + 32'(4 * i)) bad++;
        checks++;
        if (bad != 0 || acc.size() != 4) begin
            errors++;
            $display("FAIL basic_addrs: %0d wrong of %0d accepted, want 4 ok",
                     bad, acc.size());
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= outq.size() || outq[i] !== memf(32'h100 + 32'(4 * i)))
                bad++;
        checks++;
        if (bad != 0 || outq.size() != 4) begin
            errors++;
            $display("FAIL basic_data: %0d wrong of %0d words, want 4 ok",
                     bad, outq.size());
        end
    endtask

    task automatic test_waitreq();
        bit tmo;
        int bad;
        clear_logs();
        wait_mode = 2;
        wait_addr = 32'h104;
        wait_left = 3;
        start_xfer(32'h100, 16'd4);
        wait_done(200, tmo);
        step(2);
        wait_mode = 0;
        checks++;
        if (tmo || waited != 3 || hold_viol != 0) begin
            errors++;
            $display("FAIL wait_hold: tmo=%b waited=%0d viol=%0d want 0/3/0",
                     tmo, waited, hold_viol);
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= acc.size() || acc[i] !== 32'h100 + 32'(4 * i)) bad++;
        checks++;
        if (bad != 0 || acc.size() != 4) begin
            errors++;
            $display("FAIL wait_addrs: %0d wrong of %0d accepted, want 4 ok",
                     bad, acc.size());
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= outq.size() || outq[i] !== memf(32'h100 + 32'(4 * i)))
                bad++;
        checks++;
        if (bad != 0 || outq.size() != 4) begin
            errors++;
            $display("FAIL wait_data: %0d wrong of %0d words, want 4 ok",
                     bad, outq.size());
        end
    endtask

    task automatic test_backpressure();
        bit tmo;
        int bad;
        clear_logs();
        rdy_force = 0;
        start_xfer(32'h2000, 16'd20);
        step(40);
        checks++;
        if (acc.size() != 8 || AVL_READ !== 1'b0 || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: accepted=%0d read=%b valid=%b want 8/0/1",
                     acc.size(), AVL_READ, OUT_VALID);
        end
        rdy_force = 1;
        wait_done(400, tmo);
        step(2);
        bad = 0;
        for (int i = 0; i < 20; i++)
            if (i >= outq.size() || outq[i] !== memf(32'h2000 + 32'(4 * i)))
                bad++;
        checks++;
        if (tmo || bad != 0 || outq.size() != 20 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_drain: tmo=%b bad=%0d words=%0d dones=%0d want 0/0/20/1",
                     tmo, bad, outq.size(), done_cnt);
        end
    endtask

    task automatic test_zero_and_busy();
        bit tmo;
        clear_logs();
        start_xfer(32'h500, 16'd0);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b want 1/1", DONE, BUSY);
        end
        step(1);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL zero_end: done=%b busy=%b want 0/0", DONE, BUSY);
        end
        step(3);
        checks++;
        if (rd_cycles != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_bus: read cycles=%0d dones=%0d want 0/1",
                     rd_cycles, done_cnt);
        end
        clear_logs();
        rdy_force = 0;
        start_xfer(32'h4000, 16'd4);
        step(2);
        start_xfer(32'h9000, 16'd2);
        step(10);
        rdy_force = 1;
        wait_done(200, tmo);
        step(4);
        checks++;
        if (tmo || acc.size() != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: tmo=%b accepted=%0d dones=%0d want 0/4/1",
                     tmo, acc.size(), done_cnt);
        end
        checks++;
        if (acc.size() < 4 || acc[3] !== 32'h400C
            || outq.size() != 4) begin
            errors++;
            $display("FAIL busy_start_addr: words=%0d want 4 from 0x4000..0x400c",
                     outq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        int k;
        clear_logs();
        lat_fix = 10;
        start_xfer(32'h3000, 16'd8);
        k = 0;
        while (acc.size() < 4 && k < 50) begin
            step(1);
            k++;
        end
        ov_seen = 0;
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        k = 0;
        while (pend.size() > 0 && k < 50) begin
            step(1);
            k++;
        end
        step(3);
        checks++;
        if (pend.size() != 0 || ov_seen != 0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: pend=%0d valid cycles=%0d want 0/0",
                     pend.size(), ov_seen);
        end
        checks++;
        if (AVL_READ !== 1'b0 || BUSY !== 1'b0 || AVL_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_state: read=%b busy=%b addr=%h want 0/0/0",
                     AVL_READ, BUSY, AVL_ADDR);
        end
        clear_logs();
        lat_fix = 2;
        start_xfer(32'h3100, 16'd2);
        wait_done(100, tmo);
        step(2);
        checks++;
        if (tmo || outq.size() != 2 || acc.size() != 2) begin
            errors++;
            $display("FAIL rst_mid_restart: tmo=%b words=%0d acc=%0d want 0/2/2",
                     tmo, outq.size(), acc.size());
        end else begin
            checks++;
            if (outq[0] !== memf(32'h3100) || outq[1] !== memf(32'h3104)) begin
                errors++;
                $display("FAIL rst_mid_data: got %h %h want %h %h",
                         outq[0], outq[1], memf(32'h3100), memf(32'h3104));
            end
        end
    endtask

    task automatic test_random();
        bit tmo;
        int bad;
        logic [31:0] base;
        base = 32'hFFFF_FF00;
        clear_logs();
        wait_mode = 1;
        lat_rand = 1;
        rdy_rand = 1;
        start_xfer(base, 16'd1000);
        wait_done(30000, tmo);
        step(5);
        wait_mode = 0;
        lat_rand = 0;
        rdy_rand = 0;
        checks++;
        if (tmo || done_cnt != 1) begin
            errors++;
            $display("FAIL rand_done: tmo=%b dones=%0d want 0/1", tmo, done_cnt);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++)
            if (i >= outq.size() || outq[i] !== memf(base + 32'(4 * i)))
                bad++;
        checks++;
        if (bad != 0 || outq.size() != 1000) begin
            errors++;
            $display("FAIL rand_data: %0d wrong of %0d words, want 1000 ok",
                     bad, outq.size());
        end
        bad = 0;
        for (int i = 0; i < 1000; i++)
            if (i >= acc.size() || acc[i] !== base + 32'(4 * i)) bad++;
        checks++;
        if (bad != 0 || acc.size() != 1000) begin
            errors++;
            $display("FAIL rand_addrs: %0d wrong of %0d accepted, want 1000 ok",
                     bad, acc.size());
        end
        checks++;
        if (max_out > 8 || hold_viol != 0) begin
            errors++;
            $display("FAIL rand_credit: max outstanding=%0d viol=%0d want <=8/0",
                     max_out, hold_viol);
        end
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        BASE_ADDR = 32'h0;
        WORD_COUNT = 16'h0;
        AVL_WAITREQUEST = 1'b0;
        AVL_READDATA = 32'h0;
        AVL_READDATAVALID = 1'b0;
        OUT_READY = 1'b1;
        clear_logs();
        test_reset();
        test_basic();
        test_waitreq();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
